// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
//
// Key-driven LED mode controller for a two-key / two-LED board.
// Both active-low keys are synchronised and debounced. Each clean press
// becomes a single-cycle event. A mode state machine and a blink-rate timer
// then sequence the two active-low LEDs through off / blink / alternate /
// steady-on patterns.
//
// Parameters
//   DEBOUNCE_CYC : consecutive stable cycles needed to accept a key change
//   HALF_PERIOD  : blink half-period in cycles at speed index 0
//
// Ports
//   sys_clk : system clock, rising edge
//   sys_rst : asynchronous active-high reset
//   key     : raw key pins, active low, asynchronous (key[0]=KEY0, key[1]=KEY1)
//   led     : LED drive, active low (1 = off), registered
//   mode    : current mode 0 OFF, 1 BLINK, 2 ALT, 3 ON, registered
//   speed   : current blink rate index 0..2, registered
// -----------------------------------------------------------------------------
module led_mode_ctrl #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int HALF_PERIOD  = 25_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [1:0] key,
   output logic [1:0] led,
   output logic [1:0] mode,
   output logic [1:0] speed
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYC) + 1;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [31:0]      HALF_P  = 32'(HALF_PERIOD);

   typedef enum logic [1:0] {
      M_OFF   = 2'd0,
      M_BLINK = 2'd1,
      M_ALT   = 2'd2,
      M_ON    = 2'd3
   } mode_t;

   // ---------------------------------------------------------------------------
   // Stage p0: two-flop synchroniser. Resets to "released" so that reset
   // never looks like a press.
   // ---------------------------------------------------------------------------
   logic [1:0] key_meta_p0;
   logic [1:0] key_sync_p0;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         key_meta_p0 <= 2'b11;
         key_sync_p0 <= 2'b11;
      end else begin
         key_meta_p0 <= key;
         key_sync_p0 <= key_meta_p0;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p1: per-key debounce and press-event generation.
   // The counter only runs while the synchronised level disagrees with the
   // accepted level; any agreeing sample restarts it, so a glitch shorter
   // than DEBOUNCE_CYC cycles is absorbed. The event is registered on the
   // same edge the stable level falls, giving a one-cycle pulse per press.
   // ---------------------------------------------------------------------------
   logic [1:0]       stable_p1;
   logic [CNT_W-1:0] db_cnt_p1 [2];
   logic [1:0]       accept;
   logic [1:0]       press_evt_p1;

   always_comb begin
      accept = 2'b00;
      for (int i = 0; i < 2; i++) begin
         accept[i] = (key_sync_p0[i] != stable_p1[i]) && (db_cnt_p1[i] == DB_LAST);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         stable_p1    <= 2'b11;
         press_evt_p1 <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            db_cnt_p1[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            // Only a 1->0 acceptance is a press; releases are silent.
            press_evt_p1[i] <= accept[i] & ~key_sync_p0[i];
            if (key_sync_p0[i] == stable_p1[i]) begin
               db_cnt_p1[i] <= '0;
            end else if (accept[i]) begin
               stable_p1[i] <= key_sync_p0[i];
               db_cnt_p1[i] <= '0;
            end else begin
               db_cnt_p1[i] <= db_cnt_p1[i] + CNT_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p2: mode / speed state machine.
   // Simultaneous KEY0 and KEY1 events act as a "panic" return to OFF at the
   // slowest rate.
   // ---------------------------------------------------------------------------
   mode_t      mode_p2;
   mode_t      mode_nxt;
   logic [1:0] speed_p2;
   logic [1:0] speed_nxt;
   logic       mode_chg;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         mode_p2  <= M_OFF;
         speed_p2 <= 2'd0;
      end else begin
         mode_p2  <= mode_nxt;
         speed_p2 <= speed_nxt;
      end
   end

   always_comb begin
      mode_nxt  = mode_p2;
      speed_nxt = speed_p2;
      case (press_evt_p1)
         2'b11: begin
            mode_nxt  = M_OFF;
            speed_nxt = 2'd0;
         end
         2'b01: begin
            case (mode_p2)
               M_OFF:   mode_nxt = M_BLINK;
               M_BLINK: mode_nxt = M_ALT;
               M_ALT:   mode_nxt = M_ON;
               default: mode_nxt = M_OFF;
            endcase
         end
         2'b10: begin
            speed_nxt = (speed_p2 >= 2'd2) ? 2'd0 : speed_p2 + 2'd1;
         end
         default: begin
            mode_nxt  = mode_p2;
            speed_nxt = speed_p2;
         end
      endcase
   end

   assign mode_chg = (mode_nxt != mode_p2);

   // ---------------------------------------------------------------------------
   // Stage p3: blink timer.
   // The >= compare lets a speed increase that lowers the limit below the
   // running count wrap on the very next cycle instead of running on to 2^32.
   // A mode change restarts the pattern from phase 0 on the same edge the
   // mode register updates.
   // ---------------------------------------------------------------------------
   logic [31:0] limit;
   logic [31:0] limit_m1;
   logic        blink_run;
   logic [31:0] count_p3;
   logic        phase_p3;

   always_comb begin
      limit     = HALF_P >> speed_p2;
      limit_m1  = (limit == 32'd0) ? 32'd0 : limit - 32'd1;
      blink_run = (mode_p2 == M_BLINK) || (mode_p2 == M_ALT);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         count_p3 <= 32'd0;
         phase_p3 <= 1'b0;
      end else if (mode_chg || !blink_run) begin
         count_p3 <= 32'd0;
         phase_p3 <= 1'b0;
      end else if (count_p3 >= limit_m1) begin
         count_p3 <= 32'd0;
         phase_p3 <= ~phase_p3;
      end else begin
         count_p3 <= count_p3 + 32'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p4: LED pattern register (active low).
   // ---------------------------------------------------------------------------
   logic [1:0] led_nxt;
   logic [1:0] led_p4;

   always_comb begin
      led_nxt = 2'b11;
      case (mode_p2)
         M_OFF:   led_nxt = 2'b11;
         M_BLINK: led_nxt = phase_p3 ? 2'b11 : 2'b00;
         M_ALT:   led_nxt = phase_p3 ? 2'b10 : 2'b01;
         M_ON:    led_nxt = 2'b00;
         default: led_nxt = 2'b11;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         led_p4 <= 2'b11;
      end else begin
         led_p4 <= led_nxt;
      end
   end

   assign led   = led_p4;
   assign mode  = mode_p2;
   assign speed = speed_p2;

endmodule
